// File: rtl/proc_pkg.sv
// Shared types and default widths for the processor memory path.
// Holds the arbiter FSM state encoding and the owner codes.
package proc_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_D  = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Winner select between fetch and data requesters.
// MEM_ARB_RR_EN selects round-robin on conflict; default is data first.
module arb_pick (
    input  logic if_req,
    input  logic d_req,
    input  logic last_owner,
    output logic owner
);
    import proc_pkg::*;

`ifdef MEM_ARB_RR_EN
    // On conflict the side that was not granted last wins.
    always_comb begin
        owner = OWNER_IF;
        if (if_req && d_req) begin
            owner = ~last_owner;
        end else if (d_req) begin
            owner = OWNER_D;
        end
    end
`else
    logic unused_last_owner;
    assign unused_last_owner = last_owner;

    // Fixed priority: data beats fetch.
    always_comb begin
        owner = OWNER_IF;
        if (d_req) begin
            owner = OWNER_D;
        end
        if (!d_req && !if_req) begin
            owner = OWNER_IF;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: grant, issue, wait, respond.
// Build option MEM_ARB_RR_EN enables round-robin conflict resolution.
module mem_arbiter #(
    parameter int ADDR_W  = proc_pkg::ADDR_W,
    parameter int DATA_W  = proc_pkg::DATA_W,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    import proc_pkg::*;

    localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

    arb_state_t state;
    logic [3:0] cnt;
    logic       owner;
    logic       is_store;
    logic       pick;
    logic       last_owner;
    logic       any_req;

    assign any_req = if_req || d_req;

    arb_pick u_pick (
        .if_req     (if_req),
        .d_req      (d_req),
        .last_owner (last_owner),
        .owner      (pick)
    );

`ifdef MEM_ARB_RR_EN
    // Remember who was granted most recently for the next conflict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_owner <= OWNER_IF;
        end else if (state == IDLE && any_req) begin
            last_owner <= pick;
        end
    end
`else
    assign last_owner = OWNER_IF;
`endif

    // Access sequencer. WAIT spans the full memory latency so the word
    // is captured on its last cycle and shown to the owner in RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            owner     <= OWNER_IF;
            is_store  <= 1'b0;
            if_gnt    <= 1'b0;
            d_gnt     <= 1'b0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            mem_en    <= 1'b0;
            mem_rw    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            if_gnt    <= 1'b0;
            d_gnt     <= 1'b0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            mem_en    <= 1'b0;
            mem_rw    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        state    <= ISSUE;
                        owner    <= pick;
                        is_store <= (pick == OWNER_D) && d_we;
                        mem_en   <= 1'b1;
                        if (pick == OWNER_D) begin
                            d_gnt    <= 1'b1;
                            mem_rw   <= d_we;
                            mem_addr <= d_addr;
                            if (d_we) begin
                                mem_wdata <= d_wdata;
                            end
                        end else begin
                            if_gnt   <= 1'b1;
                            mem_addr <= if_addr;
                        end
                    end
                end
                ISSUE: begin
                    cnt   <= LAT_LOAD;
                    state <= WAIT;
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                        if (owner == OWNER_D) begin
                            d_rvalid <= 1'b1;
                            if (!is_store) begin
                                d_rdata <= mem_rdata;
                            end
                        end else begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= mem_rdata;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter (MEM_LAT=2 main, MEM_LAT=1 side).
// Vector table, directed corner cases and a random transaction model.
module tb_mem_arbiter;
    import proc_pkg::*;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_we;
    logic [9:0]  if_addr, d_addr;
    logic [31:0] d_wdata;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid;
    logic [31:0] if_rdata, d_rdata;
    logic        mem_en, mem_rw;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic        if_req1;
    logic [9:0]  if_addr1;
    logic        if_gnt1, if_rvalid1, d_gnt1, d_rvalid1;
    logic [31:0] if_rdata1, d_rdata1;
    logic        mem_en1, mem_rw1;
    logic [9:0]  mem_addr1;
    logic [31:0] mem_wdata1, mem_rdata1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .if_req(if_req1), .if_addr(if_addr1), .if_gnt(if_gnt1),
        .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
        .d_req(1'b0), .d_we(1'b0), .d_addr(10'd0), .d_wdata(32'd0),
        .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
        .mem_en(mem_en1), .mem_rw(mem_rw1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
    );

    function automatic logic [31:0] f_init(input int i);
        return (i == 5) ? 32'hDEADBEEF : (32'hA5000000 ^ 32'(i));
    endfunction

    // Memory with LAT-cycle read pipeline; idle read bus shows a marker.
    bit          mem_init;
    bit   [1:0]  pv;
    logic [9:0]  pa0, pa1;
    logic [31:0] rd1;
    logic [31:0] mem [1024];

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= f_init(i);
            mem_init <= 1'b1;
        end else if (mem_en && mem_rw) begin
            mem[mem_addr] <= mem_wdata;
        end
        pv  <= {pv[0], mem_en & ~mem_rw};
        pa0 <= mem_addr;
        pa1 <= pa0;
        rd1 <= mem_en1 ? mem[mem_addr1] : 32'hBAD0BAD0;
    end

    assign mem_rdata  = pv[1] ? mem[pa1] : 32'hBAD0BAD0;
    assign mem_rdata1 = rd1;

    // Reference state at transaction level.
    logic [31:0] ref_mem [1024];
    logic [31:0] exp_if_rd, exp_d_rd;
`ifdef MEM_ARB_RR_EN
    logic rr_last;
`endif

    function automatic logic pick_model(input logic i, input logic d);
`ifdef MEM_ARB_RR_EN
        if (i && d) return ~rr_last;
`endif
        return d ? OWNER_D : OWNER_IF;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One access from the IDLE cycle whose requests are already driven.
    // drop: 0 keep requests, 1 drop winner, 2 drop both.
    task automatic xact(input logic own, input logic we,
                        input logic [9:0] addr, input logic [31:0] wd,
                        input int drop);
        @(posedge clk);
        @(negedge clk);
        chk("if_gnt", 32'(if_gnt), 32'(own == OWNER_IF));
        chk("d_gnt", 32'(d_gnt), 32'(own == OWNER_D));
        chk("mem_en", 32'(mem_en), 32'd1);
        chk("mem_rw", 32'(mem_rw), 32'(we));
        chk("mem_addr", 32'(mem_addr), 32'(addr));
        chk("mem_wdata", mem_wdata, we ? wd : 32'h0);
        @(posedge clk);
        #1;
        if (drop == 1) begin
            if (own == OWNER_D) d_req = 1'b0;
            else if_req = 1'b0;
        end else if (drop == 2) begin
            if_req = 1'b0;
            d_req  = 1'b0;
        end
        for (int k = 0; k < LAT; k++) begin
            @(negedge clk);
            chk("busy_quiet", 32'({if_gnt, d_gnt, mem_en, if_rvalid, d_rvalid}), 32'd0);
            @(posedge clk);
        end
        @(negedge clk);
        chk("if_rvalid", 32'(if_rvalid), 32'(own == OWNER_IF));
        chk("d_rvalid", 32'(d_rvalid), 32'(own == OWNER_D));
        chk("if_rdata", if_rdata, exp_if_rd);
        chk("d_rdata", d_rdata, exp_d_rd);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        is_d;
        logic        we;
        logic [9:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        logic own;
        tbl[0] = '{1'b0, 1'b0, 10'd5,    32'h0,        32'hDEADBEEF};
        tbl[1] = '{1'b1, 1'b1, 10'd9,    32'h12345678, 32'h00000000};
        tbl[2] = '{1'b1, 1'b0, 10'd9,    32'h0,        32'h12345678};
        tbl[3] = '{1'b0, 1'b0, 10'd9,    32'h0,        32'h12345678};
        tbl[4] = '{1'b1, 1'b0, 10'd1023, 32'h0,        32'hA50003FF};
        tbl[5] = '{1'b0, 1'b0, 10'd0,    32'h0,        32'hA5000000};
        tbl[6] = '{1'b1, 1'b1, 10'd0,    32'hFFFFFFFF, 32'hA50003FF};
        tbl[7] = '{1'b0, 1'b0, 10'd0,    32'h0,        32'hFFFFFFFF};

        for (int i = 0; i < 1024; i++) ref_mem[i] = f_init(i);
        exp_if_rd = '0;
        exp_d_rd  = '0;
        rst = 1'b1;
        if_req = 0; d_req = 0; d_we = 0;
        if_addr = '0; d_addr = '0; d_wdata = '0;
        if_req1 = 0; if_addr1 = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_flags", 32'({if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_rw}), 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_dut1", 32'({if_gnt1, if_rvalid1, d_gnt1, d_rvalid1, mem_en1, mem_rw1}), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Lone-request vectors.
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].is_d) begin
                d_req = 1'b1; d_we = tbl[i].we;
                d_addr = tbl[i].addr; d_wdata = tbl[i].wd;
                exp_d_rd = tbl[i].exp_rd;
                if (tbl[i].we) ref_mem[tbl[i].addr] = tbl[i].wd;
            end else begin
                if_req = 1'b1; if_addr = tbl[i].addr;
                exp_if_rd = tbl[i].exp_rd;
            end
            xact(tbl[i].is_d, tbl[i].is_d & tbl[i].we, tbl[i].addr, tbl[i].wd, 1);
        end

        // Conflict: data first, fetch MEM_LAT+3 cycles later.
        if_req = 1'b1; if_addr = 10'd7;
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'd5;
        exp_d_rd = 32'hDEADBEEF;
        xact(OWNER_D, 1'b0, 10'd5, 32'h0, 1);
        exp_if_rd = 32'hA5000007;
        xact(OWNER_IF, 1'b0, 10'd7, 32'h0, 1);

        // Both held for four accesses.
        if_req = 1'b1; if_addr = 10'd3;
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'd4;
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
            own = (i % 2 == 0) ? OWNER_D : OWNER_IF;
`else
            own = OWNER_D;
`endif
            if (own == OWNER_D) exp_d_rd = 32'hA5000004;
            else exp_if_rd = 32'hA5000003;
            xact(own, 1'b0, own ? 10'd4 : 10'd3, 32'h0, (i == 3) ? 2 : 0);
        end

        // Reset while waiting on memory.
        if_req = 1'b1; if_addr = 10'd5;
        @(posedge clk);
        @(negedge clk);
        chk("rstw_gnt", 32'(if_gnt), 32'd1);
        @(posedge clk);
        #1;
        if_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstw_flags", 32'({if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_rw}), 32'd0);
        chk("rstw_if_rdata", if_rdata, 32'd0);
        chk("rstw_d_rdata", d_rdata, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_if_rd = '0;
        exp_d_rd  = '0;
        for (int k = 0; k < LAT + 3; k++) begin
            @(negedge clk);
            chk("rstw_no_rvalid", 32'({if_rvalid, d_rvalid, mem_en}), 32'd0);
        end
        @(posedge clk);
        #1;

        // Reset in ISSUE drops mem_en without waiting for a clock.
        if_req = 1'b1; if_addr = 10'd9;
        @(posedge clk);
        #2;
        chk("rsti_en_before", 32'(mem_en), 32'd1);
        rst = 1'b1;
        #1;
        chk("rsti_en_async", 32'({mem_en, if_gnt}), 32'd0);
        if_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        if_req = 1'b1; if_addr = 10'd5;
        exp_if_rd = 32'hDEADBEEF;
        xact(OWNER_IF, 1'b0, 10'd5, 32'h0, 1);

        // Random traffic against the transaction model.
`ifdef MEM_ARB_RR_EN
        rr_last = OWNER_IF;
`endif
        for (int r = 0; r < 60; r++) begin
            if (!if_req && $urandom_range(0, 1) == 1) begin
                if_req  = 1'b1;
                if_addr = ($urandom_range(0, 3) == 0) ? 10'($urandom)
                                                      : 10'($urandom_range(0, 15));
            end
            if (!d_req && $urandom_range(0, 1) == 1) begin
                d_req   = 1'b1;
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = ($urandom_range(0, 3) == 0) ? 10'($urandom)
                                                      : 10'($urandom_range(0, 15));
                d_wdata = $urandom;
            end
            if (!if_req && !d_req) begin
                @(negedge clk);
                chk("idle_quiet", 32'({if_gnt, d_gnt, mem_en, if_rvalid, d_rvalid}), 32'd0);
                @(posedge clk);
                #1;
                continue;
            end
            own = pick_model(if_req, d_req);
`ifdef MEM_ARB_RR_EN
            rr_last = own;
`endif
            if (own == OWNER_D) begin
                if (d_we) ref_mem[d_addr] = d_wdata;
                else exp_d_rd = ref_mem[d_addr];
            end else begin
                exp_if_rd = ref_mem[if_addr];
            end
            xact(own, own & d_we, own ? d_addr : if_addr, d_wdata, 1);
        end
        if_req = 1'b0;
        d_req  = 1'b0;

        // MEM_LAT=1 instance: response two cycles after the grant.
        if_req1 = 1'b1; if_addr1 = 10'd5;
        @(posedge clk);
        @(negedge clk);
        chk("l1_gnt", 32'({if_gnt1, mem_en1, mem_rw1, d_gnt1}), 32'b1100);
        chk("l1_addr", 32'(mem_addr1), 32'd5);
        @(posedge clk);
        #1;
        if_req1 = 1'b0;
        @(negedge clk);
        chk("l1_early", 32'({if_rvalid1, mem_en1}), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("l1_rvalid", 32'({if_rvalid1, d_rvalid1}), 32'b10);
        chk("l1_rdata", if_rdata1, 32'hDEADBEEF);
        chk("l1_quiet_bus", mem_wdata1 | d_rdata1, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("l1_after", 32'(if_rvalid1), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
